// File: rtl/rs_enc_lfsr.sv
// Systematic RS(MSG_LEN+4, MSG_LEN) encoder over GF(2^8) (poly 0x11D, alpha 0x02, t=2).
// Define RS_ENC_ABORT_EN to add the enc_abort input, which discards the codeword in flight.
module rs_enc_lfsr #(
    parameter int MSG_LEN = 251
) (
    input  logic       clk,
    input  logic       rst,
`ifdef RS_ENC_ABORT_EN
    input  logic       enc_abort,
`endif
    input  logic       msg_valid,
    input  logic [7:0] msg_data,
    output logic       msg_ready,
    output logic       cw_valid,
    output logic [7:0] cw_data,
    output logic       cw_parity,
    output logic       cw_last
);
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] G3       = 8'h0F;
    localparam logic [DATA_W-1:0] G2       = 8'h36;
    localparam logic [DATA_W-1:0] G1       = 8'h78;
    localparam logic [DATA_W-1:0] G0       = 8'h40;
    localparam logic [7:0]        LAST_CNT = 8'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PAR
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_cnt, w_cnt_nxt;
    logic [1:0]             r_pcnt, w_pcnt_nxt;
    logic [3:0][DATA_W-1:0] r_par, w_par_nxt;
    logic [DATA_W-1:0]      r_cw_data_p1, w_cw_data;
    logic                   r_cw_vld_p1, w_cw_vld;
    logic                   r_cw_par_p1, w_cw_par;
    logic                   r_cw_last_p1, w_cw_last;
    logic                   w_abort;
    logic                   w_clear;
    logic                   w_accept;
    logic [DATA_W-1:0]      w_fb;

    // Shift-and-add multiply; with a constant operand this folds to an XOR network.
    function automatic logic [DATA_W-1:0] gf_mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < DATA_W; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[DATA_W-2:0], 1'b0} ^ (sh[DATA_W-1] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

`ifdef RS_ENC_ABORT_EN
    assign w_abort = enc_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_clear   = rst | w_abort;
    assign msg_ready = ~rst & (r_state != PAR);
    assign w_accept  = msg_valid & msg_ready & ~w_abort;
    assign w_fb      = msg_data ^ r_par[3];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pcnt_nxt  = r_pcnt;
        w_par_nxt   = r_par;
        w_cw_vld    = 1'b0;
        w_cw_data   = r_cw_data_p1;
        w_cw_par    = 1'b0;
        w_cw_last   = 1'b0;
        case (r_state)
            // IDLE always holds cnt=0, so it shares the message path with MSG.
            IDLE, MSG: begin
                if (w_accept) begin
                    w_par_nxt[3] = r_par[2] ^ gf_mul(w_fb, G3);
                    w_par_nxt[2] = r_par[1] ^ gf_mul(w_fb, G2);
                    w_par_nxt[1] = r_par[0] ^ gf_mul(w_fb, G1);
                    w_par_nxt[0] = gf_mul(w_fb, G0);
                    w_cnt_nxt    = r_cnt + 8'd1;
                    w_cw_vld     = 1'b1;
                    w_cw_data    = msg_data;
                    w_state_nxt  = (r_cnt == LAST_CNT) ? PAR : MSG;
                end
            end
            PAR: begin
                w_cw_vld   = 1'b1;
                w_cw_data  = r_par[3];
                w_cw_par   = 1'b1;
                w_cw_last  = (r_pcnt == 2'd3);
                w_par_nxt  = {r_par[2:0], 8'h00};
                w_pcnt_nxt = r_pcnt + 2'd1;
                if (r_pcnt == 2'd3) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_pcnt_nxt  = 2'd0;
                    w_par_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Stage p1: registered codeword output, one cycle after accept / parity shift.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_pcnt       <= 2'd0;
            r_par        <= '0;
            r_cw_vld_p1  <= 1'b0;
            r_cw_data_p1 <= '0;
            r_cw_par_p1  <= 1'b0;
            r_cw_last_p1 <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pcnt       <= w_pcnt_nxt;
            r_par        <= w_par_nxt;
            r_cw_vld_p1  <= w_cw_vld;
            r_cw_data_p1 <= w_cw_data;
            r_cw_par_p1  <= w_cw_par;
            r_cw_last_p1 <= w_cw_last;
        end
    end

    assign cw_valid  = r_cw_vld_p1;
    assign cw_data   = r_cw_data_p1;
    assign cw_parity = r_cw_par_p1;
    assign cw_last   = r_cw_last_p1;

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Directed bench for rs_enc_lfsr: hand-computed parity vectors, syndrome checks, gaps, reset, abort.
module tb_rs_enc_lfsr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       msg_valid;
    logic [7:0] msg_data;
    logic       msg_ready;
    logic       cw_valid;
    logic [7:0] cw_data;
    logic       cw_parity;
    logic       cw_last;
`ifdef RS_ENC_ABORT_EN
    logic       enc_abort;
`endif

    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       b_cw_valid;
    logic [7:0] b_cw_data;
    logic       b_cw_parity;
    logic       b_cw_last;

    rs_enc_lfsr #(.MSG_LEN(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef RS_ENC_ABORT_EN
        .enc_abort (enc_abort),
`endif
        .msg_valid (msg_valid),
        .msg_data  (msg_data),
        .msg_ready (msg_ready),
        .cw_valid  (cw_valid),
        .cw_data   (cw_data),
        .cw_parity (cw_parity),
        .cw_last   (cw_last)
    );

    rs_enc_lfsr #(.MSG_LEN(251)) u_big (
        .clk       (clk),
        .rst       (rst),
`ifdef RS_ENC_ABORT_EN
        .enc_abort (1'b0),
`endif
        .msg_valid (b_valid),
        .msg_data  (b_data),
        .msg_ready (b_ready),
        .cw_valid  (b_cw_valid),
        .cw_data   (b_cw_data),
        .cw_parity (b_cw_parity),
        .cw_last   (b_cw_last)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] tx[4];
    logic [7:0] exp_par[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Carry-less product followed by polynomial reduction modulo 0x11D.
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] t;
        t = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) t = t ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (t[i]) t = t ^ (15'(9'h11D) << (i - 8));
        return t[7:0];
    endfunction

    task automatic run_small(input bit gaps, input bit check_exp, input string tag);
        int         acc, got, cyc, rdy_low;
        bit         was_acc, exp_v;
        logic [7:0] rx[8];
        logic [7:0] s;
        logic [7:0] apow[4];
        apow = '{8'h01, 8'h02, 8'h04, 8'h08};
        acc = 0; got = 0; cyc = 0; rdy_low = 0;
        while (got < 8 && cyc < 40) begin
            msg_valid = (acc < 4) && (!gaps || (cyc % 2 == 0));
            msg_data  = msg_valid ? tx[acc] : 8'($urandom);
            was_acc   = msg_valid && msg_ready;
            if (!msg_ready) rdy_low++;
            @(posedge clk); #1;
            if (was_acc) acc++;
            exp_v = gaps ? ((cyc > 6) || (cyc % 2 == 0)) : 1'b1;
            chk({tag, "_cw_valid"}, 32'(cw_valid), 32'(exp_v));
            if (cw_valid) begin
                rx[got] = cw_data;
                if (got < 4) chk({tag, "_msg_echo"}, 32'(cw_data), 32'(tx[got]));
                chk({tag, "_cw_parity"}, 32'(cw_parity), 32'(got >= 4));
                chk({tag, "_cw_last"}, 32'(cw_last), 32'(got == 7));
                if (cw_last) chk({tag, "_ready_after_last"}, 32'(msg_ready), 32'd1);
                got++;
            end
            cyc++;
        end
        msg_valid = 1'b0;
        chk({tag, "_cw_count"}, got, 32'd8);
        chk({tag, "_ready_low_cycles"}, rdy_low, 32'd4);
        if (check_exp)
            for (int i = 0; i < 4; i++)
                chk({tag, "_parity"}, 32'(rx[4+i]), 32'(exp_par[i]));
        for (int j = 0; j < 4; j++) begin
            s = 8'h00;
            for (int i = 0; i < got; i++) s = tb_gmul(s, apow[j]) ^ rx[i];
            chk({tag, "_syndrome"}, 32'(s), 32'd0);
        end
    endtask

    task automatic run_big(input bit zero, input string tag);
        int         acc, got, cyc, last_cyc, nz;
        bit         was_acc;
        logic [7:0] s[4];
        logic [7:0] apow[4];
        apow = '{8'h01, 8'h02, 8'h04, 8'h08};
        s    = '{8'h00, 8'h00, 8'h00, 8'h00};
        acc = 0; got = 0; cyc = 0; last_cyc = -1; nz = 0;
        while (got < 255 && cyc < 400) begin
            b_valid = (acc < 251);
            b_data  = zero ? 8'h00 : 8'($urandom);
            was_acc = b_valid && b_ready;
            @(posedge clk); #1;
            cyc++;
            if (was_acc) acc++;
            if (b_cw_valid) begin
                for (int j = 0; j < 4; j++) s[j] = tb_gmul(s[j], apow[j]) ^ b_cw_data;
                if (b_cw_data != 8'h00) nz++;
                if (b_cw_last) last_cyc = cyc;
                got++;
            end
        end
        b_valid = 1'b0;
        chk({tag, "_cw_count"}, got, 32'd255);
        chk({tag, "_last_cycle"}, last_cyc, 32'd255);
        for (int j = 0; j < 4; j++) chk({tag, "_syndrome"}, 32'(s[j]), 32'd0);
        if (zero) chk({tag, "_nonzero_symbols"}, nz, 32'd0);
    endtask

    initial begin
        int got;
        int cyc;
        int acc;
        bit was_acc;
        rst       = 1'b1;
        msg_valid = 1'b0;
        msg_data  = 8'h00;
        b_valid   = 1'b0;
        b_data    = 8'h00;
`ifdef RS_ENC_ABORT_EN
        enc_abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cw_valid", 32'(cw_valid), 32'd0);
        chk("rst_cw_data", 32'(cw_data), 32'd0);
        chk("rst_cw_parity", 32'(cw_parity), 32'd0);
        chk("rst_cw_last", 32'(cw_last), 32'd0);
        chk("rst_msg_ready", 32'(msg_ready), 32'd0);
        chk("rst_big_ready", 32'(b_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_msg_ready", 32'(msg_ready), 32'd1);

        tx      = '{8'h00, 8'h00, 8'h00, 8'h01};
        exp_par = '{8'h0F, 8'h36, 8'h78, 8'h40};
        run_small(1'b0, 1'b1, "unit");
        run_small(1'b1, 1'b1, "unit_gaps");

        tx      = '{8'h00, 8'h00, 8'h01, 8'h00};
        exp_par = '{8'h63, 8'h57, 8'hD2, 8'hE7};
        run_small(1'b0, 1'b1, "x5");

        tx = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_small(1'b0, 1'b0, "rand");

        // Reset one cycle after the 2nd parity symbol has appeared.
        tx = '{8'h5A, 8'hC3, 8'h99, 8'h17};
        got = 0; cyc = 0; acc = 0;
        while (got < 6 && cyc < 20) begin
            msg_valid = (acc < 4);
            msg_data  = (acc < 4) ? tx[acc] : 8'h00;
            was_acc   = msg_valid && msg_ready;
            @(posedge clk); #1;
            if (was_acc) acc++;
            if (cw_valid) got++;
            cyc++;
        end
        chk("midpar_reach", got, 32'd6);
        msg_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midpar_ready_in_rst", 32'(msg_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midpar_cw_valid_rst", 32'(cw_valid), 32'd0);
        chk("midpar_cw_data_rst", 32'(cw_data), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("midpar_no_more", 32'(cw_valid), 32'd0);
        end
        tx      = '{8'h00, 8'h00, 8'h01, 8'h00};
        exp_par = '{8'h63, 8'h57, 8'hD2, 8'hE7};
        run_small(1'b0, 1'b1, "after_rst");

`ifdef RS_ENC_ABORT_EN
        tx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 2; i++) begin
            msg_valid = 1'b1;
            msg_data  = tx[i];
            @(posedge clk); #1;
            chk("abort_pre_valid", 32'(cw_valid), 32'd1);
        end
        msg_data  = tx[2];
        enc_abort = 1'b1;
        @(posedge clk); #1;
        enc_abort = 1'b0;
        msg_valid = 1'b0;
        chk("abort_cw_valid", 32'(cw_valid), 32'd0);
        chk("abort_cw_data", 32'(cw_data), 32'd0);
        chk("abort_idle_ready", 32'(msg_ready), 32'd1);
        tx      = '{8'h00, 8'h00, 8'h00, 8'h01};
        exp_par = '{8'h0F, 8'h36, 8'h78, 8'h40};
        run_small(1'b0, 1'b1, "after_abort");
`endif

        run_big(1'b1, "big_zero");
        run_big(1'b0, "big_rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rs_enc_lfsr.md
RS_ENC_LFSR -- requirements
Module: rs_enc_lfsr

Interface
REQ-001 SHALL provide parameter MSG_LEN, default 251, message symbols per codeword, legal range 1..251.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port msg_valid  input  1  msg_data holds a message symbol.
REQ-005 SHALL provide port msg_data  input  8  message symbol in GF(2^8).
REQ-006 SHALL provide port msg_ready  output  1  block accepts a symbol this cycle; accept = msg_valid & msg_ready.
REQ-007 SHALL provide port cw_valid  output  1  cw_data holds a codeword symbol.
REQ-008 SHALL provide port cw_data  output  8  codeword symbol, message first, then parity.
REQ-009 SHALL provide port cw_parity  output  1  the current cw_data is a parity symbol.
REQ-010 SHALL provide port cw_last  output  1  the current cw_data is the final parity symbol of the codeword.

Function
REQ-011 SHALL implement a systematic RS(MSG_LEN+4, MSG_LEN) encoder, t=2, over GF(2^8) with primitive polynomial 0x11D and alpha=0x02.
REQ-012 SHALL use the generator g(x)=(x+a^0)(x+a^1)(x+a^2)(x+a^3)=x^4+0x0F x^3+0x36 x^2+0x78 x+0x40, consistent with the syndrome stage S0..S3.
REQ-013 SHALL hold the parity LFSR in registers p3..p0; on each accept fb=msg_data^p3, p3<=p2^0x0F*fb, p2<=p1^0x36*fb, p1<=p0^0x78*fb, p0<=0x40*fb.
REQ-014 SHALL build the constant multiplies from the existing gf2m8_multi block or equivalent XOR networks; no lookup ROMs.
REQ-015 SHALL have FSM states IDLE, MSG and PAR, with an 8-bit symbol counter cnt and a 2-bit parity counter pcnt.
REQ-016 IDLE: msg_ready=1, LFSR=0, cnt=0; on the first accept go to MSG, or to PAR when MSG_LEN=1.
REQ-017 MSG: msg_ready=1; each accept increments cnt; the accept that makes cnt reach MSG_LEN goes to PAR; msg_valid=0 cycles (gaps) hold all state.
REQ-018 PAR: msg_ready=0 for exactly 4 cycles; each cycle shifts the LFSR out p3 first (p3<=p2, p2<=p1, p1<=p0, p0<=0); after pcnt=3, go to IDLE with LFSR and counters cleared.
REQ-019 SHALL register every accepted message symbol to cw_data with cw_valid=1 and cw_parity=0 one cycle after its accept (latency 1).
REQ-020 SHALL present each parity symbol on cw_data one cycle after its PAR cycle, with cw_valid=1 and cw_parity=1; cw_last=1 only with the 4th parity symbol (old p0).
REQ-021 SHALL give cw_valid=0 in every cycle with no accept and no PAR shift; cw_data then holds its last value.
REQ-022 With gapless input, SHALL sustain one codeword per MSG_LEN+4 cycles, and the next codeword's first symbol SHALL be accepted in the cycle after the last PAR cycle.
REQ-023 SHALL provide no downstream backpressure; the consumer accepts every cw_valid cycle.

Reset
REQ-024 While rst=1 at a clk edge, SHALL force state=IDLE, cnt=0, pcnt=0, p3..p0=0x00, cw_valid=0, cw_data=0x00, cw_parity=0 and cw_last=0.
REQ-025 SHALL drive msg_ready=0 during any cycle with rst=1.
REQ-026 A reset asserted mid-MSG or mid-PAR SHALL discard the partial codeword and emit no further symbols from it.

Configuration
REQ-027 With macro RS_ENC_ABORT_EN defined, SHALL add input enc_abort (1 bit); enc_abort=1 at an edge SHALL act as REQ-024 without affecting msg_ready timing beyond that cycle.
REQ-028 enc_abort SHALL take priority over an accept in the same cycle, and that symbol SHALL be dropped.
REQ-029 Without RS_ENC_ABORT_EN, the enc_abort port and its logic SHALL be absent.

Verification
REQ-030 MSG_LEN=251, all-zero message, gapless -> 255 cw symbols 0x00; parity 00,00,00,00; cw_last on cycle 255 after first accept.
REQ-031 MSG_LEN=4, message 00,00,00,01 -> parity 0x0F,0x36,0x78,0x40 with cw_parity=1; cw_last on 0x40.
REQ-032 MSG_LEN=251, random message -> 255 cw symbols fed to the syndrome stage give S0..S3=0x00, and the KES stage reports lambda0=0x01, lambda1=lambda2=0x00.
REQ-033 MSG_LEN=4, msg_valid toggling 1,0,1,0 -> cw_valid pattern mirrors it delayed 1 cycle; parity equals the gapless result; msg_ready=0 for exactly 4 cycles.
REQ-034 rst=1 for 1 cycle after the 2nd parity output -> no further cw_valid; the next codeword encodes correctly from a clean LFSR.
REQ-035 RS_ENC_ABORT_EN defined, enc_abort=1 during the 3rd accept -> that symbol dropped, cw_valid=0 next cycle, FSM in IDLE.
